// File: rtl/id_stage_pipelined.sv
// Pipelined MIPS decode stage: register file, control decode, immediate extension and ID/EX
// register with fetch handshake, stall/flush and load-use bubbling. Optional: ID_WB_BYPASS_EN.
module id_stage_pipelined #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned NUM_REGS = 32,
    parameter int unsigned PC_W     = 32,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_valid,
    input  logic [31:0]       if_instruction,
    input  logic [PC_W-1:0]   if_pc_next,
    output logic              id_ready,
    input  logic              ex_stall,
    input  logic              flush,
    input  logic              wb_reg_write,
    input  logic [ADDR_W-1:0] wb_write_register,
    input  logic [DATA_W-1:0] wb_write_data,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_imm_ext,
    output logic [DATA_W-1:0] ex_read_data1,
    output logic [DATA_W-1:0] ex_read_data2,
    output logic [PC_W-1:0]   ex_pc_next,
    output logic              ex_RegDst,
    output logic              ex_RegWrite,
    output logic              ex_ALUSrc,
    output logic              ex_MemWrite,
    output logic              ex_MemRead,
    output logic              ex_MemToReg,
    output logic              ex_Branch,
    output logic [1:0]        ex_load_mode,
    output logic [2:0]        ex_ALUOp,
    output logic              hazard_stall
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpLh    = 6'h21;
    localparam logic [5:0] OpLb    = 6'h20;
    localparam logic [5:0] OpSw    = 6'h2B;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpAndi  = 6'h0C;
    localparam logic [5:0] OpOri   = 6'h0D;
    localparam logic [5:0] OpSlti  = 6'h0A;

    typedef struct packed {
        logic              valid;
        logic              reg_dst;
        logic              reg_write;
        logic              alu_src;
        logic              mem_write;
        logic              mem_read;
        logic              mem_to_reg;
        logic              branch;
        logic [1:0]        load_mode;
        logic [2:0]        alu_op;
        logic [ADDR_W-1:0] rs;
        logic [ADDR_W-1:0] rt;
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] imm_ext;
        logic [DATA_W-1:0] rdata1;
        logic [DATA_W-1:0] rdata2;
        logic [PC_W-1:0]   pc_next;
    } id_ex_t;

    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    logic [DATA_W-1:0] regs [NUM_REGS];
    id_ex_t            ex_q, ex_d, dec;
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] rs, rt, rd;
    logic              zero_ext, uses_rt, hazard;

    assign opcode = if_instruction[31:26];
    assign rs     = if_instruction[21 +: ADDR_W];
    assign rt     = if_instruction[16 +: ADDR_W];
    assign rd     = if_instruction[11 +: ADDR_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_reg_write && wb_write_register != '0 && idx_ok(wb_write_register)) begin
            regs[wb_write_register] <= wb_write_data;
        end
    end

    always_comb begin
        dec          = '0;
        zero_ext     = 1'b0;
        dec.valid    = 1'b1;
        unique case (opcode)
            OpRtype: begin dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b010; end
            OpLw, OpLh, OpLb: begin
                dec.reg_write  = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.load_mode  = (opcode == OpLh) ? 2'b01 : (opcode == OpLb) ? 2'b10 : 2'b00;
            end
            OpSw:   begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
            OpBeq:  begin dec.branch = 1'b1; dec.alu_op = 3'b001; end
            OpAddi: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; end
            OpAndi: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b011; zero_ext = 1'b1; end
            OpOri:  begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b100; zero_ext = 1'b1; end
            OpSlti: begin dec.reg_write = 1'b1; dec.alu_src = 1'b1; dec.alu_op = 3'b101; end
            default: ;
        endcase
        dec.rs      = rs;
        dec.rt      = rt;
        dec.rd      = rd;
        dec.pc_next = if_pc_next;
        dec.imm_ext = zero_ext ? {{(DATA_W-16){1'b0}}, if_instruction[15:0]}
                               : {{(DATA_W-16){if_instruction[15]}}, if_instruction[15:0]};
        if (rs != '0 && idx_ok(rs)) dec.rdata1 = regs[rs];
        if (rt != '0 && idx_ok(rt)) dec.rdata2 = regs[rt];
`ifdef ID_WB_BYPASS_EN
        // Write-first: a same-cycle writeback is visible to this decode.
        if (wb_reg_write && rs != '0 && idx_ok(rs) && wb_write_register == rs) begin
            dec.rdata1 = wb_write_data;
        end
        if (wb_reg_write && rt != '0 && idx_ok(rt) && wb_write_register == rt) begin
            dec.rdata2 = wb_write_data;
        end
`endif
    end

    // rt is a source only for R-type, beq and sw; elsewhere it is the destination.
    assign uses_rt = (opcode == OpRtype) || (opcode == OpBeq) || (opcode == OpSw);
    assign hazard  = ex_q.valid && ex_q.mem_read && (ex_q.rt != '0) && if_valid &&
                     ((ex_q.rt == rs) || (uses_rt && ex_q.rt == rt));

    assign id_ready     = !rst && !ex_stall && !hazard;
    assign hazard_stall = hazard && !ex_stall && !flush;

    always_comb begin
        ex_d = ex_q;
        if (flush) begin
            ex_d = '0;
        end else if (ex_stall) begin
            ex_d = ex_q;
        end else if (hazard || !if_valid) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex_valid      = ex_q.valid;
    assign ex_rs         = ex_q.rs;
    assign ex_rt         = ex_q.rt;
    assign ex_rd         = ex_q.rd;
    assign ex_imm_ext    = ex_q.imm_ext;
    assign ex_read_data1 = ex_q.rdata1;
    assign ex_read_data2 = ex_q.rdata2;
    assign ex_pc_next    = ex_q.pc_next;
    assign ex_RegDst     = ex_q.reg_dst;
    assign ex_RegWrite   = ex_q.reg_write;
    assign ex_ALUSrc     = ex_q.alu_src;
    assign ex_MemWrite   = ex_q.mem_write;
    assign ex_MemRead    = ex_q.mem_read;
    assign ex_MemToReg   = ex_q.mem_to_reg;
    assign ex_Branch     = ex_q.branch;
    assign ex_load_mode  = ex_q.load_mode;
    assign ex_ALUOp      = ex_q.alu_op;

endmodule

// File: tb/tb_id_stage_pipelined.sv
// Bench for id_stage_pipelined: directed scenarios then random traffic against a reference model.
module tb_id_stage_pipelined;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instruction;
    logic [31:0] if_pc_next;
    logic        id_ready;
    logic        ex_stall;
    logic        flush;
    logic        wb_reg_write;
    logic [4:0]  wb_write_register;
    logic [31:0] wb_write_data;
    logic        ex_valid;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_imm_ext, ex_read_data1, ex_read_data2, ex_pc_next;
    logic        ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemToReg;
    logic        ex_Branch;
    logic [1:0]  ex_load_mode;
    logic [2:0]  ex_ALUOp;
    logic        hazard_stall;

    always #5 clk = ~clk;

    id_stage_pipelined dut (
        .clk               (clk),
        .rst               (rst),
        .if_valid          (if_valid),
        .if_instruction    (if_instruction),
        .if_pc_next        (if_pc_next),
        .id_ready          (id_ready),
        .ex_stall          (ex_stall),
        .flush             (flush),
        .wb_reg_write      (wb_reg_write),
        .wb_write_register (wb_write_register),
        .wb_write_data     (wb_write_data),
        .ex_valid          (ex_valid),
        .ex_rs             (ex_rs),
        .ex_rt             (ex_rt),
        .ex_rd             (ex_rd),
        .ex_imm_ext        (ex_imm_ext),
        .ex_read_data1     (ex_read_data1),
        .ex_read_data2     (ex_read_data2),
        .ex_pc_next        (ex_pc_next),
        .ex_RegDst         (ex_RegDst),
        .ex_RegWrite       (ex_RegWrite),
        .ex_ALUSrc         (ex_ALUSrc),
        .ex_MemWrite       (ex_MemWrite),
        .ex_MemRead        (ex_MemRead),
        .ex_MemToReg       (ex_MemToReg),
        .ex_Branch         (ex_Branch),
        .ex_load_mode      (ex_load_mode),
        .ex_ALUOp          (ex_ALUOp),
        .hazard_stall      (hazard_stall)
    );

    // ctrl = {RegDst,RegWrite,ALUSrc,MemWrite,MemRead,MemToReg,Branch,ALUOp[2:0],load_mode[1:0]}
    typedef struct packed {
        logic        valid;
        logic [11:0] ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm, rd1, rd2, pc;
    } exp_t;

    exp_t        model_ex;
    logic [31:0] model_regs [32];
    logic [31:0] pc_ctr;
    logic        obs_rdy, obs_hz;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [11:0] ref_ctrl(input logic [5:0] op);
        case (op)
            6'h00:   return 12'b1100000_010_00;
            6'h23:   return 12'b0110110_000_00;
            6'h21:   return 12'b0110110_000_01;
            6'h20:   return 12'b0110110_000_10;
            6'h2B:   return 12'b0011000_000_00;
            6'h04:   return 12'b0000001_001_00;
            6'h08:   return 12'b0110000_000_00;
            6'h0C:   return 12'b0110000_011_00;
            6'h0D:   return 12'b0110000_100_00;
            6'h0A:   return 12'b0110000_101_00;
            default: return 12'b0;
        endcase
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_reg_write && wb_write_register == idx) return wb_write_data;
`endif
        return model_regs[idx];
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] imm);
        return {op, s, t, imm};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic compare_ex();
        check("ex_valid", ex_valid, model_ex.valid);
        check("ctrl", {ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemToReg,
                       ex_Branch, ex_ALUOp, ex_load_mode}, model_ex.ctrl);
        check("fields", {ex_rs, ex_rt, ex_rd}, {model_ex.rs, model_ex.rt, model_ex.rd});
        check("imm_ext", ex_imm_ext, model_ex.imm);
        check("read_data1", ex_read_data1, model_ex.rd1);
        check("read_data2", ex_read_data2, model_ex.rd2);
        check("pc_next", ex_pc_next, model_ex.pc);
    endtask

    // Inputs are already applied (posedge+1); checks handshake at negedge, ID/EX after the edge.
    task automatic cycle();
        logic [5:0] op;
        logic [4:0] s, t;
        logic       hz;
        exp_t       n;
        @(negedge clk);
        op = if_instruction[31:26];
        s  = if_instruction[25:21];
        t  = if_instruction[20:16];
        hz = model_ex.valid && model_ex.ctrl[7] && model_ex.rt != 5'd0 && if_valid &&
             (model_ex.rt == s || ((op == 6'h00 || op == 6'h04 || op == 6'h2B) &&
                                   model_ex.rt == t));
        obs_rdy = id_ready;
        obs_hz  = hazard_stall;
        check("id_ready", id_ready, !ex_stall && !hz);
        check("hazard_stall", hazard_stall, hz && !ex_stall && !flush);
        n = '0;
        if (!flush && ex_stall) begin
            n = model_ex;
        end else if (!flush && !hz && if_valid) begin
            n.valid = 1'b1;
            n.ctrl  = ref_ctrl(op);
            n.rs    = s;
            n.rt    = t;
            n.rd    = if_instruction[15:11];
            n.imm   = (op == 6'h0C || op == 6'h0D) ? {16'h0, if_instruction[15:0]}
                                                   : {{16{if_instruction[15]}}, if_instruction[15:0]};
            n.rd1   = ref_read(s);
            n.rd2   = ref_read(t);
            n.pc    = if_pc_next;
        end
        if (wb_reg_write && wb_write_register != 5'd0) model_regs[wb_write_register] = wb_write_data;
        @(posedge clk);
        #1;
        model_ex = n;
        compare_ex();
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                         input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        if_valid          = v;
        if_instruction    = ins;
        if_pc_next        = pc_ctr;
        pc_ctr            = pc_ctr + 32'd4;
        ex_stall          = st;
        flush             = fl;
        wb_reg_write      = ww;
        wb_write_register = wr;
        wb_write_data     = wd;
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic st, input logic fl,
                        input logic ww, input logic [4:0] wr, input logic [31:0] wd);
        drive(v, ins, st, fl, ww, wr, wd);
        cycle();
    endtask

    task automatic model_reset();
        model_ex = '0;
        for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    endtask

    logic [5:0] ops [12];

    initial begin
        ops = '{6'h00, 6'h23, 6'h21, 6'h20, 6'h2B, 6'h04, 6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h3F,
                6'h11};
        pc_ctr = 32'h0000_1000;
        rst    = 1'b1;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_ex();
        check("ready_in_reset", id_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh register file reads zero.
        step(1'b1, rtype(5'd5, 5'd6, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("r5_after_reset", ex_read_data1, 32'd0);

        // Write then read; r0 stays zero.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h1234);
        step(1'b1, rtype(5'd3, 5'd3, 5'd1), 1'b0, 1'b0, 1'b1, 5'd0, 32'h55);
        check("wr_rd_data1", ex_read_data1, 32'h1234);
        check("wr_rd_data2", ex_read_data2, 32'h1234);
        check("wr_rd_regdst", ex_RegDst, 1'b1);
        check("wr_rd_aluop", ex_ALUOp, 3'b010);
        step(1'b1, rtype(5'd0, 5'd0, 5'd1), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("r0_read", ex_read_data1, 32'd0);

        // Load-use on rs, on sw's rt, and none for addi.
        step(1'b1, itype(6'h23, 5'd1, 5'd2, 16'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, rtype(5'd2, 5'd5, 5'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_hazard", obs_hz, 1'b1);
        check("lu_ready", obs_rdy, 1'b0);
        check("lu_bubble", ex_valid, 1'b0);
        step(1'b1, rtype(5'd2, 5'd5, 5'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lu_issue_hz", obs_hz, 1'b0);
        check("lu_issue_rd", {ex_valid, ex_rd}, {1'b1, 5'd4});
        step(1'b1, itype(6'h23, 5'd1, 5'd2, 16'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, itype(6'h2B, 5'd3, 5'd2, 16'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("sw_hazard", obs_hz, 1'b1);
        step(1'b1, itype(6'h23, 5'd1, 5'd2, 16'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        step(1'b1, itype(6'h08, 5'd0, 5'd7, 16'd5), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("addi_no_hazard", obs_hz, 1'b0);
        check("addi_issued", ex_valid, 1'b1);

        // Stall holds for three cycles, then flush beats stall.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rtype(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
            check("stall_ready", obs_rdy, 1'b0);
            check("stall_hold_imm", ex_imm_ext, 32'd5);
        end
        step(1'b1, rtype(5'd1, 5'd2, 5'd3), 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        check("flush_over_stall", ex_valid, 1'b0);

        // Immediates and unknown opcode.
        step(1'b1, itype(6'h08, 5'd0, 5'd1, 16'hFFFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("addi_sext", ex_imm_ext, 32'hFFFF_FFFF);
        step(1'b1, itype(6'h0D, 5'd0, 5'd1, 16'hFFFF), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("ori_zext", ex_imm_ext, 32'h0000_FFFF);
        step(1'b1, itype(6'h21, 5'd0, 5'd3, 16'd4), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("lh_mode", ex_load_mode, 2'b01);
        step(1'b1, itype(6'h3F, 5'd0, 5'd0, 16'd0), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        check("op3f_ctrl", {ex_valid, ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead,
                            ex_MemToReg, ex_Branch, ex_ALUOp, ex_load_mode}, 13'h1000);

        // Same-cycle writeback versus decode.
        step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h11);
        step(1'b1, rtype(5'd9, 5'd0, 5'd1), 1'b0, 1'b0, 1'b1, 5'd9, 32'hAA);
`ifdef ID_WB_BYPASS_EN
        check("bypass_on", ex_read_data1, 32'hAA);
`else
        check("bypass_off", ex_read_data1, 32'h11);
`endif

        // Reset arriving mid-stall drops the held instruction.
        step(1'b1, itype(6'h08, 5'd0, 5'd7, 16'd5), 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        drive(1'b1, rtype(5'd1, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_ex();
        check("ready_mid_reset", id_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            logic [5:0] op;
            op = ops[$urandom_range(0, 11)];
            if (op == 6'h11) op = 6'($urandom);
            step($urandom_range(0, 4) != 0,
                 {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 11'($urandom)},
                 $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage_pipelined.md
Name: id_stage_pipelined

Overview:
Parametrised successor of the single-issue decode stage. It holds the register file, control decode, immediate extension and the ID/EX pipeline register. It adds a valid/ready handshake toward fetch, stall and flush from downstream, load-use hazard bubbling, and clean reset. It sits between IF/ID and EX and replaces the fixed #5 input-delay modelling with fully synchronous behaviour.

Parameters:
DATA_W, 32, register/datapath width (>=32; immediates extend to DATA_W)
NUM_REGS, 32, architectural registers (2..32; index width ADDR_W = $clog2(NUM_REGS))
PC_W, 32, width of the next-PC value carried through

Ports:
clk  in  1  stage clock, all state on rising edge
rst  in  1  asynchronous active-high reset
if_valid  in  1  fetch presents an instruction
if_instruction  in  32  MIPS-format instruction
if_pc_next  in  PC_W  PC+4 from fetch
id_ready  out  1  stage accepts if_instruction this cycle
ex_stall  in  1  EX cannot accept; hold ID/EX register
flush  in  1  kill the instruction entering ID/EX (branch taken)
wb_reg_write  in  1  writeback enable
wb_write_register  in  ADDR_W  writeback index
wb_write_data  in  DATA_W  writeback value
ex_valid  out  1  ID/EX register holds a live instruction
ex_rs, ex_rt, ex_rd  out  ADDR_W each  instr[25:21], [20:16], [15:11], truncated to ADDR_W
ex_imm_ext  out  DATA_W  instr[15:0], sign-extended (zero-extended for andi/ori)
ex_read_data1, ex_read_data2  out  DATA_W  register values for rs and rt
ex_pc_next  out  PC_W  carried PC+4
ex_RegDst, ex_RegWrite, ex_ALUSrc, ex_MemWrite, ex_MemRead, ex_MemToReg, ex_Branch  out  1 each  control signals
ex_load_mode  out  2  00 word, 01 half, 10 byte
ex_ALUOp  out  3  ALU operation class
hazard_stall  out  1  load-use bubble inserted this cycle

Behaviour:
- Reset (async, rst=1): all registers cleared to 0; every ex_* output 0; id_ready=0 while rst is high.
- Register file: register 0 always reads 0; writes to register 0 are ignored. Write occurs at the rising edge when wb_reg_write=1. Index >= NUM_REGS: the write is dropped and the read returns 0.
- Decode by opcode. Each entry lists RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg, Branch, ALUOp, load_mode:
  - 0x00 R-type: 1,1,0,0,0,0,0, 010
  - 0x23 lw: 0,1,1,0,1,1,0, 000, 00
  - 0x21 lh: as lw, load_mode 01
  - 0x20 lb: as lw, load_mode 10
  - 0x2B sw: 0,0,1,1,0,0,0, 000
  - 0x04 beq: 0,0,0,0,0,0,1, 001
  - 0x08 addi: 0,1,1,0,0,0,0, 000
  - 0x0C andi: ALUOp 011, zero-extend
  - 0x0D ori: ALUOp 100, zero-extend
  - 0x0A slti: ALUOp 101
  - Any other opcode: all controls 0, ex_valid still follows if_valid.
- Load-use hazard: asserted when ex_valid & ex_MemRead & ex_rt!=0 & if_valid & (ex_rt==rs, or ex_rt==rt for opcodes R-type, beq or sw).
- id_ready = !rst & !ex_stall & !hazard. hazard_stall = hazard & !ex_stall & !flush.
- ID/EX update priority per edge:
  1. flush: ex_valid<=0, controls<=0
  2. ex_stall: hold all ex_*
  3. hazard: bubble; ex_valid<=0, controls<=0, fetch holds
  4. otherwise: load decoded values, ex_valid<=if_valid
- When ex_valid<=0, control outputs are 0 and datapath outputs are don't-care (implemented as 0).
- Latency: 1 cycle from acceptance to ex_valid.
- Simultaneous flush and stall: flush wins. Reset mid-stall drops the held instruction.

Optional Feature:
ID_WB_BYPASS_EN
- Defined: write-first bypass. If wb_reg_write and wb_write_register equals the rs/rt being read (and is nonzero), the read returns wb_write_data in the same cycle.
- Undefined: reads return the pre-write register contents, and software must separate a writeback from a dependent decode by one cycle.

Test Plan:
- Reset: assert rst mid-cycle → all ex_* read 0 immediately and id_ready=0. Release, then read r5 → 0.
- Write then read: WB writes r3=0x1234, next cycle decode add r1,r3,r3 → ex_read_data1=ex_read_data2=0x1234, ex_RegDst=1, ex_ALUOp=010. Write to r0 → reads 0.
- Load-use: lw r2,0(r1) followed by add r4,r2,r5 → one bubble cycle with hazard_stall=1, id_ready=0, ex_valid=0, then add issues. sw r2 after lw r2 also stalls; addi r7,r0,5 after lw r2 does not.
- Stall/flush: hold ex_stall=1 for 3 cycles → ex_* constant and id_ready=0. Assert flush and ex_stall together → ex_valid=0 next edge.
- Immediates: addi with imm 0xFFFF → ex_imm_ext=0xFFFFFFFF. ori with 0xFFFF → 0x0000FFFF. lh → load_mode 01. Opcode 0x3F → all controls 0.
- Bypass (macro on): WB writes r9=0xAA in the same cycle that add r1,r9,r0 is decoded → ex_read_data1=0xAA. With the macro off → the old value is returned.
